// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a scan-code FIFO.
// Path: raw ps2_clk/ps2_data -> synchronisers -> clock glitch filter -> frame FSM -> FIFO.
// Make-code counting is built only when PS2_KEYCNT_EN is defined. Otherwise key_count is 0.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          nextdata_n,
    input  logic                          flush,
    input  logic                          err_clr,
    output logic [7:0]                    data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          busy,
    output logic [15:0]                   key_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

    // Data bits plus parity must XOR to 1 (odd parity).
    function automatic logic odd_parity_ok(input logic [8:0] v);
        return (^v) == 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r, data_sync_r;
    logic                   sclk_s, sdata_s;
    logic                   fclk_r, fclk_d_r, strobe_s;
    logic [FW-1:0]          fcnt_r;
    state_t                 state_r, state_nx;
    logic [3:0]             bit_cnt_r, bit_cnt_nx;
    logic [9:0]             shift_r, shift_nx;
    logic [TW-1:0]          tcnt_r, tcnt_nx;
    logic                   good_s, perr_set_s, ferr_set_s;
    logic [7:0]             mem_r [FIFO_DEPTH];
    logic [AW-1:0]          w_ptr_r, r_ptr_r;
    logic [CW-1:0]          count_r, count_nx;
    logic                   ready_r, full_s, pop_s, push_s, ovf_set_s;
    logic                   overflow_r, parity_err_r, frame_err_r;

    assign sclk_s  = clk_sync_r[SYNC_STAGES-1];
    assign sdata_s = data_sync_r[SYNC_STAGES-1];

    // Synchronise both raw PS/2 lines into the clk domain. They idle high.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_r  <= '1;
            data_sync_r <= '1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Glitch filter: fclk follows sclk only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fclk_r   <= 1'b1;
            fclk_d_r <= 1'b1;
            fcnt_r   <= '0;
        end else begin
            fclk_d_r <= fclk_r;
            if (sclk_s == fclk_r) begin
                fcnt_r <= '0;
            end else if (fcnt_r == FW'(FILTER_LEN - 1)) begin
                fclk_r <= sclk_s;
                fcnt_r <= '0;
            end else begin
                fcnt_r <= fcnt_r + FW'(1);
            end
        end
    end

    // A falling edge of the filtered clock gives the one-cycle bit sample strobe.
    assign strobe_s = fclk_d_r & ~fclk_r;

    // Frame FSM state, bit position, shift register and inter-edge timeout counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 10'd0;
            tcnt_r    <= '0;
        end else begin
            state_r   <= state_nx;
            bit_cnt_r <= bit_cnt_nx;
            shift_r   <= shift_nx;
            tcnt_r    <= tcnt_nx;
        end
    end

    // Next-state logic. The frame is checked on the same strobe that delivers the stop bit.
    always_comb begin
        state_nx   = state_r;
        bit_cnt_nx = bit_cnt_r;
        shift_nx   = shift_r;
        tcnt_nx    = '0;
        good_s     = 1'b0;
        perr_set_s = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (strobe_s) begin
                    state_nx   = RECV;
                    shift_nx   = {9'd0, sdata_s};
                    bit_cnt_nx = 4'd1;
                end else begin
                    state_nx = IDLE;
                end
            end
            RECV: begin
                if (strobe_s) begin
                    if (bit_cnt_r == 4'd10) begin
                        state_nx   = IDLE;
                        bit_cnt_nx = 4'd0;
                        if (shift_r[0] != 1'b0 || sdata_s != 1'b1) begin
                            ferr_set_s = 1'b1;
                        end else if (!odd_parity_ok(shift_r[9:1])) begin
                            perr_set_s = 1'b1;
                        end else begin
                            good_s = 1'b1;
                        end
                    end else begin
                        shift_nx[bit_cnt_r] = sdata_s;
                        bit_cnt_nx          = bit_cnt_r + 4'd1;
                    end
                end else if (tcnt_r >= TW'(TIMEOUT_CYC)) begin
                    state_nx   = IDLE;
                    bit_cnt_nx = 4'd0;
                    ferr_set_s = 1'b1;
                end else begin
                    tcnt_nx = tcnt_r + TW'(1);
                end
            end
            default: begin
                state_nx   = IDLE;
                bit_cnt_nx = 4'd0;
            end
        endcase
    end

    // A push is accepted when there is room or a pop frees a slot. flush discards everything.
    assign full_s    = (count_r == CW'(FIFO_DEPTH));
    assign pop_s     = ~nextdata_n & ready_r & ~flush;
    assign push_s    = good_s & (~full_s | pop_s) & ~flush;
    assign ovf_set_s = good_s & full_s & ~(~nextdata_n & ready_r) & ~flush;

    // Occupancy bookkeeping for simultaneous push and pop.
    always_comb begin
        count_nx = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx = count_r + CW'(1);
            2'b01:   count_nx = count_r - CW'(1);
            default: count_nx = count_r;
        endcase
    end

    // FIFO pointers, occupancy and ready flag. flush has priority.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr_r <= '0;
            r_ptr_r <= '0;
            count_r <= '0;
            ready_r <= 1'b0;
        end else if (flush) begin
            w_ptr_r <= '0;
            r_ptr_r <= '0;
            count_r <= '0;
            ready_r <= 1'b0;
        end else begin
            if (push_s) w_ptr_r <= w_ptr_r + AW'(1);
            if (pop_s)  r_ptr_r <= r_ptr_r + AW'(1);
            count_r <= count_nx;
            ready_r <= (count_nx != CW'(0));
        end
    end

    // FIFO storage. It is not reset.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[w_ptr_r] <= shift_r[8:1];
    end

    // Sticky error flags. A set event in the same cycle wins over err_clr.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            overflow_r   <= ovf_set_s  | (overflow_r   & ~err_clr);
            parity_err_r <= perr_set_s | (parity_err_r & ~err_clr);
            frame_err_r  <= ferr_set_s | (frame_err_r  & ~err_clr);
        end
    end

`ifdef PS2_KEYCNT_EN
    logic [7:0]  last_make_r;
    logic        last_valid_r, brk_r;
    logic [15:0] kcnt_r;
    logic [7:0]  push_byte_s;
    assign push_byte_s = shift_r[8:1];

    // Count distinct make codes. Break sequences and typematic repeats are not counted.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_make_r  <= 8'h00;
            last_valid_r <= 1'b0;
            brk_r        <= 1'b0;
            kcnt_r       <= 16'd0;
        end else if (push_s) begin
            if (push_byte_s == 8'hF0) begin
                brk_r <= 1'b1;
            end else if (push_byte_s == 8'hE0) begin
                brk_r <= brk_r;
            end else if (brk_r) begin
                brk_r <= 1'b0;
                if (push_byte_s == last_make_r) last_valid_r <= 1'b0;
            end else if (last_valid_r && push_byte_s == last_make_r) begin
                kcnt_r <= kcnt_r;
            end else begin
                kcnt_r       <= kcnt_r + 16'd1;
                last_make_r  <= push_byte_s;
                last_valid_r <= 1'b1;
            end
        end else begin
            kcnt_r <= kcnt_r;
        end
    end
    assign key_count = kcnt_r;
`else
    assign key_count = 16'h0000;
`endif

    assign data       = ready_r ? mem_r[r_ptr_r] : 8'h00;
    assign ready      = ready_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = (state_r == RECV);
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo. A queue-based model tracks FIFO contents, sticky flags and make-code count.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
`ifdef PS2_KEYCNT_EN
    localparam bit KC_EN = 1'b1;
`else
    localparam bit KC_EN = 1'b0;
`endif

    logic        clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic        nextdata_n = 1'b1, flush = 1'b0, err_clr = 1'b0;
    logic [7:0]  data;
    logic        ready, overflow, parity_err, frame_err, busy;
    logic [3:0]  fifo_count;
    logic [15:0] key_count;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .FILTER_LEN(4), .TIMEOUT_CYC(5000)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .flush(flush), .err_clr(err_clr),
        .data(data), .ready(ready), .fifo_count(fifo_count), .overflow(overflow),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy), .key_count(key_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  q[$];
    logic        m_ovf = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;
    logic [15:0] m_kc = 16'd0;
    logic [7:0]  m_last = 8'h00;
    logic        m_lvalid = 1'b0, m_brk = 1'b0;
    logic        settled = 1'b0;
    logic [7:0]  cmp_head;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare every settled cycle against the model.
    always @(negedge clk) begin
        if (settled) begin
            cmp_head = (q.size() > 0) ? q[0] : 8'h00;
            check("cycle_state",
                  {data, ready, fifo_count, overflow, parity_err, frame_err, busy, key_count},
                  {cmp_head, q.size() != 0, 4'(q.size()), m_ovf, m_perr, m_ferr, 1'b0, m_kc});
        end
    end

    task automatic model_key(input logic [7:0] b);
        if (KC_EN) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE0) m_brk = m_brk;
            else if (m_brk) begin
                m_brk = 1'b0;
                if (b == m_last) m_lvalid = 1'b0;
            end else if (m_lvalid && b == m_last) m_kc = m_kc;
            else begin
                m_kc = m_kc + 16'd1;
                m_last = b;
                m_lvalid = 1'b1;
            end
        end
    endtask

    task automatic model_frame(input logic [10:0] f);
        if (f[0] !== 1'b0 || f[10] !== 1'b1) m_ferr = 1'b1;
        else if ((^f[9:1]) !== 1'b1) m_perr = 1'b1;
        else if (q.size() >= DEPTH) m_ovf = 1'b1;
        else begin
            q.push_back(f[8:1]);
            model_key(f[8:1]);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input bit badpar, input bit badstart, input bit badstop);
        logic par;
        par = (~^b) ^ badpar;
        return {~badstop, par, b, badstart};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n, input int hp, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (hp) @(posedge clk);
            #1;
            if (glitch && i == 4) begin
                ps2_clk = 1'b0;
                repeat (2) @(posedge clk);
                #1 ps2_clk = 1'b1;
                repeat (hp) @(posedge clk);
                #1;
            end
            ps2_clk = 1'b0;
            repeat (hp / 2) @(posedge clk);
            #1;
            if (glitch && i == 6) begin
                ps2_clk = 1'b1;
                repeat (2) @(posedge clk);
                #1 ps2_clk = 1'b0;
            end
            repeat (hp - hp / 2) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f, input int hp, input bit glitch);
        settled = 1'b0;
        send_bits(f, 11, hp, glitch);
        repeat (hp) @(posedge clk);
        #1;
        model_frame(f);
        settled = 1'b1;
    endtask

    task automatic pop_n(input int n);
        @(posedge clk);
        #1 nextdata_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) void'(q.pop_front());
        end
        nextdata_n = 1'b1;
    endtask

    task automatic do_err_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        q.delete();
    endtask

    logic [7:0] kstream [9] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hE0, 8'hF0, 8'h32};
    logic [7:0] rset [6] = '{8'h1C, 8'h32, 8'hF0, 8'hE0, 8'h23, 8'h1C};

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {data, ready, fifo_count, overflow, parity_err, frame_err, busy, key_count}, 64'd0);
        clrn = 1'b1;
        repeat (5) @(posedge clk);
        #1 settled = 1'b1;

        // 1: single good frame
        send_frame(mkframe(8'h1C, 0, 0, 0), 50, 0);
        check("t1_data", data, 8'h1C);
        check("t1_count", {ready, fifo_count}, {1'b1, 4'd1});
        check("t1_flags", {overflow, parity_err, frame_err}, 3'b000);
        pop_n(1);
        check("t1_after_pop", {ready, data}, {1'b0, 8'h00});

        // 2: overflow with nine frames and no pops
        for (int i = 1; i <= 9; i++) send_frame(mkframe(8'(8'h10 + i), 0, 0, 0), 30, 0);
        check("t2_count", fifo_count, 4'd8);
        check("t2_overflow", overflow, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            check("t2_order", data, 8'(8'h10 + i));
            pop_n(1);
        end
        check("t2_empty", ready, 1'b0);
        do_err_clr();
        check("t2_ovf_clr", overflow, 1'b0);

        // 3: parity error and then stop-bit error
        send_frame(mkframe(8'h1C, 1, 0, 0), 30, 0);
        check("t3_parity", {parity_err, frame_err, fifo_count}, {1'b1, 1'b0, 4'd0});
        send_frame(mkframe(8'h1C, 0, 0, 1), 30, 0);
        check("t3_frame", {frame_err, fifo_count}, {1'b1, 4'd0});
        do_err_clr();

        // 4: timeout after five bits, then good 8'h32
        settled = 1'b0;
        send_bits(mkframe(8'h55, 0, 0, 0), 5, 50, 0);
        repeat (10) @(posedge clk);
        #1 check("t4_busy", busy, 1'b1);
        repeat (5100) @(posedge clk);
        #1 check("t4_abort", {busy, frame_err}, {1'b0, 1'b1});
        m_ferr = 1'b1;
        settled = 1'b1;
        send_frame(mkframe(8'h32, 0, 0, 0), 50, 0);
        check("t4_only32", {fifo_count, data}, {4'd1, 8'h32});
        pop_n(1);
        do_err_clr();

        // 5: short clock glitches mid-frame are ignored
        send_frame(mkframe(8'hA7, 0, 0, 0), 50, 1);
        check("t5_glitch", {fifo_count, data, frame_err, parity_err}, {4'd1, 8'hA7, 2'b00});
        pop_n(1);

        // 6: make-code stream, then async reset mid-frame
        for (int i = 0; i < 9; i++) begin
            send_frame(mkframe(kstream[i], 0, 0, 0), 25, 0);
            pop_n(1);
        end
        check("t6_keycount", key_count, KC_EN ? 16'd2 : 16'd0);
        settled = 1'b0;
        send_bits(mkframe(8'h44, 0, 0, 0), 4, 30, 0);
        repeat (10) @(posedge clk);
        #1 check("t6_busy_pre", busy, 1'b1);
        #3 clrn = 1'b0;
        #1 check("t6_async_rst", {data, ready, fifo_count, overflow, parity_err, frame_err, busy, key_count}, 64'd0);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        #20 clrn = 1'b1;
        q.delete();
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        m_kc = 16'd0; m_brk = 1'b0; m_lvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1 settled = 1'b1;
        send_frame(mkframe(8'h5A, 0, 0, 0), 30, 0);
        check("t6_after_rst", {fifo_count, data, frame_err}, {4'd1, 8'h5A, 1'b0});

        // Randomised traffic against the model
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            int r;
            r = int'($urandom_range(0, 19));
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rset[$urandom_range(0, 5)];
            send_frame(mkframe(b, r == 0, r == 1, r == 2), int'($urandom_range(20, 40)), $urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 3));
            if (r > 0 && $urandom_range(0, 1) == 0) pop_n(r);
            if ($urandom_range(0, 5) == 0) do_err_clr();
            if ($urandom_range(0, 7) == 0) do_flush();
        end
        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
